wb_align_split: RTL and testbench

WB_ALIGN_SPLIT -- requirements
Module: wb_align_split

---
 rtl/wb_align_split.sv | 185 ++++++++++++++++++
 tb/tb_wb_align_split.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_align_split.sv
// wb_align_split: Wishbone-style bridge that splits a misaligned 16-bit CPU
// access into two byte accesses (LO, one idle GAP cycle, HI) toward the memory
// map and reassembles read data. Aligned words and byte accesses go through as
// a single downstream phase. Each downstream phase has a wait-cycle timeout.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   wbs_adr_i/dat_i/we_i    CPU request (byte address, write data, write enable)
//   wbs_byte_i, wbs_stb_i   byte access select, request strobe
//   wbs_dat_o               read data to CPU, held until the next completion
//   wbs_ack_o, wbs_err_o    one-cycle completion pulse, timeout flag
//   wbm_adr_o/dat_o/we_o    downstream address, write data, write enable
//   wbm_byte_o, wbm_stb_o   downstream byte select, strobe
//   wbm_dat_i, wbm_ack_i    downstream read data, acknowledge
module wb_align_split #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [19:0] wbs_adr_i,
    input  logic [15:0] wbs_dat_i,
    output logic [15:0] wbs_dat_o,
    input  logic        wbs_we_i,
    input  logic        wbs_byte_i,
    input  logic        wbs_stb_i,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic [19:0] wbm_adr_o,
    output logic [15:0] wbm_dat_o,
    input  logic [15:0] wbm_dat_i,
    output logic        wbm_we_o,
    output logic        wbm_byte_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i
);

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 8;
    localparam int unsigned CW = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        GAP  = 3'd2,
        HI   = 3'd3,
        ACK  = 3'd4
    } state_t;

    state_t        state;
    logic [AW-1:0] adr_q;
    logic [BW-1:0] dat_hi_q;
    logic          mis_q;
    logic          byte_q;
    logic [BW-1:0] lo_byte;
    logic [CW-1:0] wait_cnt;
    logic          cancel;

    // Request withdrawn at any point since the transaction was accepted
    logic          cancel_now_c;
    // Next no-ack cycle would bring the wait counter to TIMEOUT
    logic [CW-1:0] wait_inc_c;
    logic          expire_c;

    assign cancel_now_c = cancel | ~wbs_stb_i;
    assign wait_inc_c   = wait_cnt + CW'(1);
    assign expire_c     = (wait_inc_c == TIMEOUT);

    // Transaction FSM with registered bus outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            adr_q     <= '0;
            dat_hi_q  <= '0;
            mis_q     <= 1'b0;
            byte_q    <= 1'b0;
            lo_byte   <= '0;
            wait_cnt  <= '0;
            cancel    <= 1'b0;
            wbs_dat_o <= '0;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_we_o  <= 1'b0;
            wbm_byte_o <= 1'b0;
            wbm_stb_o <= 1'b0;
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (wbs_stb_i) begin
                        adr_q     <= wbs_adr_i;
                        dat_hi_q  <= wbs_dat_i[15:8];
                        byte_q    <= wbs_byte_i;
                        mis_q     <= ~wbs_byte_i & wbs_adr_i[0];
                        cancel    <= 1'b0;
                        wait_cnt  <= '0;
                        wbm_we_o  <= wbs_we_i;
                        wbm_adr_o <= wbs_adr_i;
                        wbm_stb_o <= 1'b1;
                        if (~wbs_byte_i & wbs_adr_i[0]) begin
                            // Misaligned word: low byte first, data on [7:0]
                            state      <= LO;
                            wbm_byte_o <= 1'b1;
                            wbm_dat_o  <= {8'h00, wbs_dat_i[7:0]};
                        end else begin
                            state      <= HI;
                            wbm_byte_o <= wbs_byte_i;
                            wbm_dat_o  <= wbs_dat_i;
                        end
                    end
                end

                LO, HI: begin
                    if (~wbs_stb_i) begin
                        cancel <= 1'b1;
                    end
                    if (wbm_ack_i) begin
                        wbm_stb_o <= 1'b0;
                        if (state == LO) begin
                            lo_byte <= wbm_dat_i[7:0];
                            if (cancel_now_c) begin
                                state <= IDLE;
                            end else begin
                                // High byte goes to the next address, wrapping at 20 bits
                                state     <= GAP;
                                wbm_adr_o <= adr_q + AW'(1);
                                wbm_dat_o <= {8'h00, dat_hi_q};
                            end
                        end else if (cancel_now_c) begin
                            state <= IDLE;
                        end else begin
                            state     <= ACK;
                            wbs_ack_o <= 1'b1;
                            if (mis_q) begin
                                wbs_dat_o <= {wbm_dat_i[7:0], lo_byte};
                            end else if (byte_q) begin
                                wbs_dat_o <= {8'h00, wbm_dat_i[7:0]};
                            end else begin
                                wbs_dat_o <= wbm_dat_i;
                            end
                        end
                    end else if (expire_c) begin
                        // Timeout aborts the whole transaction, skipping any HI phase
                        wbm_stb_o <= 1'b0;
                        wait_cnt  <= wait_inc_c;
                        if (cancel_now_c) begin
                            state <= IDLE;
                        end else begin
                            state     <= ACK;
                            wbs_ack_o <= 1'b1;
                            wbs_err_o <= 1'b1;
                            wbs_dat_o <= DW'(16'hFFFF);
                        end
                    end else begin
                        wait_cnt <= wait_inc_c;
                    end
                end

                GAP: begin
                    if (cancel_now_c) begin
                        cancel <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        state     <= HI;
                        wbm_stb_o <= 1'b1;
                        wait_cnt  <= '0;
                    end
                end

                ACK: begin
                    state <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    wbm_stb_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_align_split.sv
// Self-checking bench for wb_align_split: directed scenarios followed by random
// transactions, checked against a byte-addressed memory reference model.
module tb_wb_align_split;

    localparam int TO = 4;

    logic        clk;
    logic        rst_i;
    logic [19:0] wbs_adr_i;
    logic [15:0] wbs_dat_i;
    logic [15:0] wbs_dat_o;
    logic        wbs_we_i;
    logic        wbs_byte_i;
    logic        wbs_stb_i;
    logic        wbs_ack_o;
    logic        wbs_err_o;
    logic [19:0] wbm_adr_o;
    logic [15:0] wbm_dat_o;
    logic [15:0] wbm_dat_i;
    logic        wbm_we_o;
    logic        wbm_byte_o;
    logic        wbm_stb_o;
    logic        wbm_ack_i;

    int errors = 0;
    int checks = 0;

    // Reference memory (updated from CPU requests) and bus-side memory
    // (updated from what the DUT actually drives downstream)
    bit [7:0] ref_mem [bit [19:0]];
    bit [7:0] bus_mem [bit [19:0]];
    logic [7:0]  hi_fill;
    logic [15:0] last_rd;
    bit          last_valid;

    wb_align_split #(.TIMEOUT(8'd4)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_dat_o  (wbs_dat_o),
        .wbs_we_i   (wbs_we_i),
        .wbs_byte_i (wbs_byte_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_err_o  (wbs_err_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_we_o   (wbm_we_o),
        .wbm_byte_o (wbm_byte_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_ack_i  (wbm_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] seed(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [19:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return seed(a);
    endfunction

    function automatic logic [7:0] bus_rd(input logic [19:0] a);
        if (bus_mem.exists(a)) return bus_mem[a];
        return seed(a);
    endfunction

    task automatic poke(input logic [19:0] a, input logic [7:0] v);
        ref_mem[a] = v;
        bus_mem[a] = v;
    endtask

    // One CPU transaction: w0/w1 are wait cycles before ack for each downstream
    // phase (>= TO means never ack); cancel_req drops the CPU strobe mid-flight.
    task automatic run_txn(input logic [19:0] a, input logic [15:0] d, input logic we,
                           input logic bt, input int w0, input int w1, input bit cancel_req);
        logic        mis;
        int          n_exp;
        int          w [2];
        logic [19:0] e_adr [2];
        logic        e_byte [2];
        logic [15:0] e_dat [2];
        int          e_len [2];
        bit          timed_out;
        logic [15:0] e_rd;
        logic [19:0] p_adr [4];
        logic        p_byte [4];
        logic        p_we [4];
        logic [15:0] p_dat [4];
        int          p_len [4];
        int          nph, gap, gap_cnt, nack, ph;
        bit          in_phase;
        logic        err_seen;
        logic [15:0] rd_seen;

        // Reference model
        mis      = !bt && a[0];
        w[0]     = w0;
        w[1]     = w1;
        e_adr[0] = a;
        e_byte[0] = mis ? 1'b1 : bt;
        e_dat[0] = mis ? {8'h00, d[7:0]} : d;
        e_adr[1] = a + 20'd1;
        e_byte[1] = 1'b1;
        e_dat[1] = {8'h00, d[15:8]};
        n_exp    = mis ? 2 : 1;
        if (w0 >= TO || cancel_req) n_exp = 1;
        timed_out = 1'b0;
        for (int p = 0; p < 2; p++) begin
            e_len[p] = (w[p] < TO) ? w[p] + 1 : TO;
            if (p < n_exp && w[p] >= TO) timed_out = 1'b1;
        end
        if (timed_out) e_rd = 16'hFFFF;
        else if (bt) e_rd = {8'h00, ref_rd(a)};
        else e_rd = {ref_rd(a + 20'd1), ref_rd(a)};
        if (we) begin
            if (mis) begin
                if (w[0] < TO) ref_mem[a] = d[7:0];
                if (n_exp == 2 && w[1] < TO) ref_mem[a + 20'd1] = d[15:8];
            end else if (w[0] < TO) begin
                ref_mem[a] = d[7:0];
                if (!bt) ref_mem[a + 20'd1] = d[15:8];
            end
        end

        for (int p = 0; p < 4; p++) begin
            p_adr[p] = '0; p_byte[p] = 1'b0; p_we[p] = 1'b0; p_dat[p] = '0; p_len[p] = 0;
        end
        nph = 0; gap = -1; gap_cnt = 0; nack = 0; in_phase = 1'b0;
        err_seen = 1'b0; rd_seen = '0;

        @(negedge clk);
        wbs_adr_i  = a;
        wbs_dat_i  = d;
        wbs_we_i   = we;
        wbs_byte_i = bt;
        wbs_stb_i  = 1'b1;

        // Bounded observation window acting as CPU and memory responder
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            wbm_ack_i = 1'b0;
            if (wbs_ack_o) begin
                nack++;
                err_seen = wbs_err_o;
                rd_seen  = wbs_dat_o;
                wbs_stb_i = 1'b0;
            end
            if (wbm_stb_o) begin
                if (!in_phase) begin
                    if (nph < 4) begin
                        p_adr[nph] = wbm_adr_o; p_byte[nph] = wbm_byte_o;
                        p_we[nph] = wbm_we_o; p_dat[nph] = wbm_dat_o;
                    end
                    if (nph == 1) gap = gap_cnt;
                    nph++;
                    in_phase = 1'b1;
                    if (cancel_req) wbs_stb_i = 1'b0;
                end
                ph = nph - 1;
                if (ph < 4) begin
                    p_len[ph]++;
                    if (p_len[ph] == ((ph < 2) ? w[ph] : 0) + 1) begin
                        wbm_ack_i = 1'b1;
                        if (wbm_byte_o) begin
                            wbm_dat_i = {hi_fill, bus_rd(wbm_adr_o)};
                            if (wbm_we_o) bus_mem[wbm_adr_o] = wbm_dat_o[7:0];
                        end else begin
                            wbm_dat_i = {bus_rd(wbm_adr_o + 20'd1), bus_rd(wbm_adr_o)};
                            if (wbm_we_o) begin
                                bus_mem[wbm_adr_o] = wbm_dat_o[7:0];
                                bus_mem[wbm_adr_o + 20'd1] = wbm_dat_o[15:8];
                            end
                        end
                        if (wbm_we_o) wbm_dat_i = 16'($urandom);
                        in_phase = 1'b0;
                        gap_cnt = 0;
                    end
                end
            end else if (in_phase) begin
                in_phase = 1'b0;
                gap_cnt = 1;
            end else if (nph > 0) begin
                gap_cnt++;
            end
        end
        wbm_ack_i = 1'b0;
        wbs_stb_i = 1'b0;

        chk("phases", nph, n_exp);
        for (int p = 0; p < n_exp; p++) begin
            chk($sformatf("ph%0d_adr", p), p_adr[p], e_adr[p]);
            chk($sformatf("ph%0d_byte", p), p_byte[p], e_byte[p]);
            chk($sformatf("ph%0d_we", p), p_we[p], we);
            if (we) begin
                if (e_byte[p]) chk($sformatf("ph%0d_wdat", p), p_dat[p][7:0], e_dat[p][7:0]);
                else chk($sformatf("ph%0d_wdat", p), p_dat[p], e_dat[p]);
            end
            chk($sformatf("ph%0d_len", p), p_len[p], e_len[p]);
        end
        if (n_exp == 2) chk("gap", gap, 1);
        chk("ack_pulses", nack, cancel_req ? 0 : 1);
        if (!cancel_req) begin
            chk("err", err_seen, timed_out);
            if (!we || timed_out) chk("rdata", rd_seen, e_rd);
            if (!we || timed_out) begin
                last_rd = e_rd; last_valid = 1'b1;
            end else begin
                last_valid = 1'b0;
            end
        end else if (last_valid) begin
            chk("rdata_hold", wbs_dat_o, last_rd);
        end
        chk("stb_idle", wbm_stb_o, 0);
    endtask

    initial begin
        logic [19:0] ra;
        logic        rbt;
        int          rw0, rw1;
        bit          seen;
        int          busy;

        rst_i = 1'b1;
        wbs_adr_i = '0; wbs_dat_i = '0; wbs_we_i = 1'b0; wbs_byte_i = 1'b0; wbs_stb_i = 1'b0;
        wbm_dat_i = '0; wbm_ack_i = 1'b0; hi_fill = 8'h00;
        last_rd = 16'h0000; last_valid = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_stb", wbm_stb_o, 0);
        chk("rst_ack", wbs_ack_o, 0);
        chk("rst_err", wbs_err_o, 0);
        chk("rst_we", wbm_we_o, 0);
        chk("rst_byte", wbm_byte_o, 0);
        chk("rst_adr", wbm_adr_o, 0);
        chk("rst_wdat", wbm_dat_o, 0);
        chk("rst_rdat", wbs_dat_o, 0);
        rst_i = 1'b0;

        // Aligned word read with two wait cycles
        poke(20'h01000, 8'hEF);
        poke(20'h01001, 8'hBE);
        hi_fill = 8'h00;
        run_txn(20'h01000, 16'h0000, 1'b0, 1'b0, 2, 0, 1'b0);
        chk("word_read_beef", wbs_dat_o, 16'hBEEF);

        // Misaligned write splits into two byte writes
        run_txn(20'h02001, 16'hA55A, 1'b1, 1'b0, 0, 1, 1'b0);
        chk("mis_wr_lo", bus_mem[20'h02001], 8'h5A);
        chk("mis_wr_hi", bus_mem[20'h02002], 8'hA5);

        // Misaligned read wrapping at the top of the address space
        poke(20'hFFFFF, 8'h34);
        poke(20'h00000, 8'h12);
        hi_fill = 8'hC9;
        run_txn(20'hFFFFF, 16'h0000, 1'b0, 1'b0, 1, 2, 1'b0);
        chk("wrap_read", wbs_dat_o, 16'h1234);

        // Byte read at odd address, upper lane ignored
        poke(20'h00003, 8'hC3);
        hi_fill = 8'h77;
        run_txn(20'h00003, 16'h0000, 1'b0, 1'b1, 0, 0, 1'b0);
        chk("byte_read", wbs_dat_o, 16'h00C3);

        // No ack: timeout after TO wait cycles
        run_txn(20'h01000, 16'h0000, 1'b0, 1'b0, 50, 0, 1'b0);
        chk("timeout_rdata", wbs_dat_o, 16'hFFFF);

        // Timeout in HI phase of a misaligned read
        run_txn(20'h04005, 16'h0000, 1'b0, 1'b0, 1, 50, 1'b0);

        // CPU withdraws during LO of a misaligned read: no HI, no ack
        run_txn(20'h05007, 16'h0000, 1'b0, 1'b0, 2, 0, 1'b1);

        // Reset asserted during LO of a misaligned write
        @(negedge clk);
        wbs_adr_i = 20'h02001; wbs_dat_i = 16'hA55A; wbs_we_i = 1'b1;
        wbs_byte_i = 1'b0; wbs_stb_i = 1'b1; wbm_ack_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (wbm_stb_o) seen = 1'b1;
        end
        chk("rst_mid_lo_seen", seen, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_mid_stb", wbm_stb_o, 0);
        chk("rst_mid_adr", wbm_adr_o, 0);
        @(negedge clk);
        wbs_stb_i = 1'b0;
        rst_i = 1'b0;
        busy = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wbm_stb_o || wbs_ack_o) busy++;
        end
        chk("rst_mid_quiet", busy, 0);
        last_rd = 16'h0000; last_valid = 1'b1;

        // Random transactions
        for (int n = 0; n < 70; n++) begin
            ra  = 20'($urandom);
            if ($urandom_range(0, 9) == 0) ra = 20'hFFFFF;
            rbt = ($urandom_range(0, 2) == 0);
            rw0 = ($urandom_range(0, 9) == 0) ? 50 : $urandom_range(0, 3);
            rw1 = ($urandom_range(0, 9) == 0) ? 50 : $urandom_range(0, 3);
            hi_fill = 8'($urandom);
            run_txn(ra, 16'($urandom), 1'($urandom), rbt, rw0, rw1, ($urandom_range(0, 7) == 0));
        end

        // Read back a few written locations to confirm memory consistency
        for (int n = 0; n < 10; n++) begin
            ra = 20'($urandom);
            run_txn(ra, 16'h0000, 1'b0, 1'b0, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
